ftoi_pipe: RTL
==============

Name: ftoi_pipe

Overview:
- Pipelined, parameterised single-precision float to signed integer converter with valid/ready handshake.
- Successor to the combinational ftoi used in the FPU datapath. Adds a configurable integer width, per-transaction rounding mode, saturation, and status flags.
- Sits between the FPU issue stage and the integer writeback path. Backpressure from writeback stalls the whole pipe.

Parameters:
- INT_W, 32, output integer width in bits. Legal range 8..64.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  converter accepts a beat this cycle.
- in_data  input  32  IEEE-754 binary32 operand.
- in_rne  input  1  rounding mode: 1 = round-to-nearest-even, 0 = truncate toward zero.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  INT_W  two's-complement result.
- out_ovf  output  1  result out of range, or operand is infinity.
- out_inv  output  1  operand is NaN.

Behaviour:
- Reset (rst=1 at an edge): both stage-valid bits cleared; out_valid=0, out_data=0, out_ovf=0, out_inv=0. A reset mid-operation discards all in-flight beats. in_ready is 1 in the first cycle after reset.
- Pipeline:
  - Two register stages; latency exactly 2 cycles from accept to out_valid with no stall.
  - Throughput is 1 beat per cycle.
- Advance and handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance, combinationally.
  - A beat is accepted when in_valid && in_ready.
  - When advance=0, every stage holds its contents and out_* are stable.
  - out_valid stays high until out_ready. No beat is dropped or duplicated.
  - Bubbles propagate: stage valid bits shift in with in_valid && in_ready.
- Stage 1:
  - Unpack sign s, exponent e, mantissa m.
  - Classify as zero/denormal, normal, inf or NaN.
  - Align {1,m} to a fixed-point magnitude with INT_W integer bits, plus guard bit, round bit and a sticky OR of the remaining bits.
- Stage 2:
  - Rounding: if RNE, increment when guard && (round || sticky || lsb). Truncate never increments.
  - Range check on the rounded magnitude: limit is 2^(INT_W-1)-1 for positive and 2^(INT_W-1) for negative. Rounding may cross the limit.
  - Negate when s=1; produce flags.
- Classification rules:
  - e < 127 (|x|<1, including zero and denormals): magnitude 0 before rounding. RNE of 0.5 gives 0; RNE of 0.75 gives 1. Negative results of 0 give 0, never -0.
  - e > 127+INT_W-1, inf, or rounded magnitude above the limit: out_ovf=1.
  - NaN (e=255, m!=0): out_inv=1, out_ovf=0.
- Flags are valid only while out_valid=1 and are held 0 otherwise.

Optional Feature:
- Macro: FTOI_SAT_EN.
- Defined: overflow returns 2^(INT_W-1)-1 for positive and -2^(INT_W-1) for negative. NaN returns 2^(INT_W-1)-1.
- Undefined: overflow and NaN both return 1 followed by INT_W-1 zeros (most-negative value), independent of sign. This is the legacy ftoi behaviour.
- Flags are identical in both builds.

Test Plan:
1. Rounding, INT_W=32, FTOI_SAT_EN defined:
   - 0x40200000 (2.5): rne=1 -> 2; rne=0 -> 2.
   - 0x40600000 (3.5): rne=1 -> 4; rne=0 -> 3.
   - 0xC0300000 (-2.75): rne=0 -> 0xFFFFFFFE; rne=1 -> 0xFFFFFFFD.
   - Result appears exactly 2 cycles after accept; flags 0.
2. Range, INT_W=32:
   - 0x4F000000 (2^31) -> 0x7FFFFFFF, ovf=1.
   - 0xCF000000 (-2^31) -> 0x80000000, ovf=0.
   - 0x7F800000 (inf) -> 0x7FFFFFFF, ovf=1.
   - 0x7FC00000 (NaN) -> 0x7FFFFFFF, inv=1.
   - Without FTOI_SAT_EN: all four -> 0x80000000, same flags.
3. Rounding into overflow, INT_W=8:
   - 0x42FF0000 (127.5), rne=1 -> 0x7F, ovf=1.
   - Same operand, rne=0 -> 0x7F, ovf=0.
   - 0xC3000000 (-128) -> 0x80, ovf=0.
4. Small values:
   - 0x3F000000 (0.5), rne=1 -> 0.
   - 0x3F400000 (0.75), rne=1 -> 1.
   - 0x80000001 (-denormal) -> 0.
   - 0x00000000 -> 0; no flags in any case.
5. Backpressure:
   - Stream 5 beats back to back; hold out_ready=0 for 3 cycles once out_valid rises.
   - in_ready=0 during the hold; out_data stable throughout.
   - All 5 results delivered in order with no loss or duplication; random in_valid/out_ready over 1000 beats checked against a reference model.
6. Reset mid-flight:
   - Assert rst for 1 cycle with 2 beats in flight.
   - Next cycle: out_valid=0, out_data=0, flags 0, in_ready=1.
   - No stale beat emerges afterwards.

Source files
------------

// File: rtl/ftoi_pipe.sv
// ftoi_pipe: binary32 -> INT_W-bit signed integer, RNE or truncate chosen per beat; FTOI_SAT_EN selects saturating results.
// Two register stages, latency 2, throughput 1; out_ready low freezes every stage and drops in_ready in the same cycle.
module ftoi_pipe #(
  parameter int INT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_rne,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_inv
);

`ifdef FTOI_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam int         AW    = INT_W + 23;
  localparam logic [7:0] EMAX  = 8'(127 + INT_W - 1);
  localparam logic [INT_W-1:0] MAXP = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MINN = {1'b1, {(INT_W-1){1'b0}}};

  logic advance;
  logic accept;

  logic             s1_vld_q,  s1_vld_d;
  logic             s1_sign_q, s1_sign_d;
  logic             s1_nan_q,  s1_nan_d;
  logic             s1_big_q,  s1_big_d;
  logic             s1_rne_q,  s1_rne_d;
  logic [INT_W-1:0] s1_mag_q,  s1_mag_d;
  logic             s1_g_q,    s1_g_d;
  logic             s1_r_q,    s1_r_d;
  logic             s1_st_q,   s1_st_d;

  logic             out_vld_q, out_vld_d;
  logic [INT_W-1:0] out_dat_q, out_dat_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_inv_q, out_inv_d;

  logic [7:0]       in_exp;
  logic [22:0]      in_man;
  logic [23:0]      in_sig;
  logic [7:0]       shamt;
  logic [AW-1:0]    aligned;
  logic             mag_g, mag_r, mag_st;
  logic [INT_W-1:0] mag_int;

  logic             inc;
  logic [INT_W:0]   rnd;
  logic             pos_over, neg_over, s2_ovf;
  logic [INT_W-1:0] s2_res;

  assign advance  = !out_vld_q || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  // Stage 1: classify and align into INT_W integer bits plus guard/round/sticky.
  always_comb begin
    in_exp  = in_data[30:23];
    in_man  = in_data[22:0];
    in_sig  = {1'b1, in_man};
    shamt   = in_exp - 8'd127;
    aligned = '0;
    mag_int = '0;
    mag_g   = 1'b0;
    mag_r   = 1'b0;
    mag_st  = 1'b0;
    if (in_exp >= 8'd127 && in_exp <= EMAX) begin
      aligned = {{(INT_W-1){1'b0}}, in_sig} << shamt;
      mag_int = aligned[AW-1:23];
      mag_g   = aligned[22];
      mag_r   = aligned[21];
      mag_st  = |aligned[20:0];
    end else if (in_exp == 8'd126) begin
      mag_g  = 1'b1;
      mag_r  = in_man[22];
      mag_st = |in_man[21:0];
    end else if (in_exp == 8'd125) begin
      mag_r  = 1'b1;
      mag_st = |in_man;
    end else if (in_exp < 8'd125) begin
      mag_st = (in_exp != 8'd0) || (in_man != 23'd0);
    end
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_sign_d = s1_sign_q;
    s1_nan_d  = s1_nan_q;
    s1_big_d  = s1_big_q;
    s1_rne_d  = s1_rne_q;
    s1_mag_d  = s1_mag_q;
    s1_g_d    = s1_g_q;
    s1_r_d    = s1_r_q;
    s1_st_d   = s1_st_q;
    if (advance) begin
      s1_vld_d = in_valid;
    end
    if (accept) begin
      s1_sign_d = in_data[31];
      s1_nan_d  = (in_exp == 8'hFF) && (in_man != 23'd0);
      // Covers infinity too: 255 is always above EMAX.
      s1_big_d  = (in_exp > EMAX) && !((in_exp == 8'hFF) && (in_man != 23'd0));
      s1_rne_d  = in_rne;
      s1_mag_d  = mag_int;
      s1_g_d    = mag_g;
      s1_r_d    = mag_r;
      s1_st_d   = mag_st;
    end
  end

  // Stage 2: round, range check against the signed limits, negate.
  always_comb begin
    inc      = s1_rne_q && s1_g_q && (s1_r_q || s1_st_q || s1_mag_q[0]);
    rnd      = {1'b0, s1_mag_q} + (INT_W+1)'(inc);
    pos_over = rnd[INT_W] || rnd[INT_W-1];
    neg_over = rnd[INT_W] || (rnd[INT_W-1] && (|rnd[INT_W-2:0]));
    s2_ovf   = !s1_nan_q && (s1_big_q || (s1_sign_q ? neg_over : pos_over));
    if (s1_nan_q) begin
      s2_res = SAT_EN ? MAXP : MINN;
    end else if (s2_ovf) begin
      s2_res = (SAT_EN && !s1_sign_q) ? MAXP : MINN;
    end else if (s1_sign_q) begin
      s2_res = -rnd[INT_W-1:0];
    end else begin
      s2_res = rnd[INT_W-1:0];
    end
  end

  // Bubbles load zeros so data and flags read 0 whenever out_valid is low.
  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_ovf_d = out_ovf_q;
    out_inv_d = out_inv_q;
    if (advance) begin
      out_vld_d = s1_vld_q;
      out_dat_d = s1_vld_q ? s2_res : '0;
      out_ovf_d = s1_vld_q && s2_ovf;
      out_inv_d = s1_vld_q && s1_nan_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_nan_q  <= 1'b0;
      s1_big_q  <= 1'b0;
      s1_rne_q  <= 1'b0;
      s1_mag_q  <= '0;
      s1_g_q    <= 1'b0;
      s1_r_q    <= 1'b0;
      s1_st_q   <= 1'b0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_ovf_q <= 1'b0;
      out_inv_q <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_sign_q <= s1_sign_d;
      s1_nan_q  <= s1_nan_d;
      s1_big_q  <= s1_big_d;
      s1_rne_q  <= s1_rne_d;
      s1_mag_q  <= s1_mag_d;
      s1_g_q    <= s1_g_d;
      s1_r_q    <= s1_r_d;
      s1_st_q   <= s1_st_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      out_ovf_q <= out_ovf_d;
      out_inv_q <= out_inv_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;
  assign out_ovf   = out_ovf_q;
  assign out_inv   = out_inv_q;

endmodule
